// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - MIPS32 decode constants, ALU codes and control patterns
// Purpose: shared opcode/funct encodings, alu_* codes, control_signal bit
// indices and per-class control patterns used by decode_ctrl and decode_stage.
package decode_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operation codes; alu_NOP doubles as the illegal-instruction code
    localparam logic [4:0] alu_NOP  = 5'd0;
    localparam logic [4:0] alu_ADD  = 5'd1;
    localparam logic [4:0] alu_ADDU = 5'd2;
    localparam logic [4:0] alu_SUB  = 5'd3;
    localparam logic [4:0] alu_SUBU = 5'd4;
    localparam logic [4:0] alu_AND  = 5'd5;
    localparam logic [4:0] alu_OR   = 5'd6;
    localparam logic [4:0] alu_XOR  = 5'd7;
    localparam logic [4:0] alu_NOR  = 5'd8;
    localparam logic [4:0] alu_SLT  = 5'd9;
    localparam logic [4:0] alu_SLTU = 5'd10;
    localparam logic [4:0] alu_SLL  = 5'd11;
    localparam logic [4:0] alu_SRL  = 5'd12;
    localparam logic [4:0] alu_SRA  = 5'd13;
    localparam logic [4:0] alu_LUI  = 5'd14;  // pass src_data2 through
    localparam logic [4:0] alu_BEQ  = 5'd15;  // taken when operands equal
    localparam logic [4:0] alu_BNE  = 5'd16;  // taken when operands differ

    // control_signal bit indices
    localparam int CTRL_WR_SEL = 0;
    localparam int CTRL_SRC2   = 1;
    localparam int CTRL_MEM_RD = 4;
    localparam int CTRL_NPC_LO = 6;

    // Control patterns: {npc[1:0], mem_wr, mem_rd, wb_en, wb_src, src2, wr_sel}
    localparam logic [7:0] ctrl_Rtype    = 8'h0F;
    localparam logic [7:0] ctrl_Itype    = 8'h0C;
    localparam logic [7:0] ctrl_Load     = 8'h18;
    localparam logic [7:0] ctrl_Store    = 8'h20;
    localparam logic [7:0] ctrl_Branch   = 8'hC2;
    localparam logic [7:0] ctrl_Jump     = 8'h80;
    localparam logic [7:0] ctrl_JumpLink = 8'h8C;
    localparam logic [7:0] ctrl_JumpReg  = 8'h40;

    typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_UPPER} imm_kind_e;

    localparam logic [1:0] NPC_JREG   = 2'b01;
    localparam logic [1:0] NPC_JIMM   = 2'b10;
    localparam logic [1:0] NPC_BRANCH = 2'b11;

endpackage

// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - combinational opcode/funct to control decoder
// Purpose: maps opcode/funct to alu_op, control pattern, immediate kind,
// register-usage flags and the illegal flag.
// Ports: opcode, funct in; alu_op, ctrl, imm_kind, uses_rs, uses_rt,
// shamt_src, link, illegal out.
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] alu_op,
    output logic [7:0] ctrl,
    output imm_kind_e  imm_kind,
    output logic       uses_rs,
    output logic       uses_rt,
    output logic       shamt_src,
    output logic       link,
    output logic       illegal
);

    always_comb begin
        alu_op    = alu_NOP;
        ctrl      = 8'h00;
        imm_kind  = IMM_SIGN;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        shamt_src = 1'b0;
        link      = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                ctrl    = ctrl_Rtype;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                case (funct)
                    // Constant shifts take shamt instead of rs
                    FN_SLL:  begin alu_op = alu_SLL; shamt_src = 1'b1; uses_rs = 1'b0; end
                    FN_SRL:  begin alu_op = alu_SRL; shamt_src = 1'b1; uses_rs = 1'b0; end
                    FN_SRA:  begin alu_op = alu_SRA; shamt_src = 1'b1; uses_rs = 1'b0; end
                    FN_SLLV: alu_op = alu_SLL;
                    FN_SRLV: alu_op = alu_SRL;
                    FN_SRAV: alu_op = alu_SRA;
                    FN_JR:   begin ctrl = ctrl_JumpReg; uses_rt = 1'b0; end
                    FN_ADD:  alu_op = alu_ADD;
                    FN_ADDU: alu_op = alu_ADDU;
                    FN_SUB:  alu_op = alu_SUB;
                    FN_SUBU: alu_op = alu_SUBU;
                    FN_AND:  alu_op = alu_AND;
                    FN_OR:   alu_op = alu_OR;
                    FN_XOR:  alu_op = alu_XOR;
                    FN_NOR:  alu_op = alu_NOR;
                    FN_SLT:  alu_op = alu_SLT;
                    FN_SLTU: alu_op = alu_SLTU;
                    default: begin
                        ctrl    = 8'h00;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI:  begin alu_op = alu_ADD;  ctrl = ctrl_Itype; uses_rs = 1'b1; end
            OP_ADDIU: begin alu_op = alu_ADDU; ctrl = ctrl_Itype; uses_rs = 1'b1; end
            OP_SLTI:  begin alu_op = alu_SLT;  ctrl = ctrl_Itype; uses_rs = 1'b1; end
            OP_SLTIU: begin alu_op = alu_SLTU; ctrl = ctrl_Itype; uses_rs = 1'b1; end
            OP_ANDI:  begin alu_op = alu_AND; ctrl = ctrl_Itype; uses_rs = 1'b1; imm_kind = IMM_ZERO; end
            OP_ORI:   begin alu_op = alu_OR;  ctrl = ctrl_Itype; uses_rs = 1'b1; imm_kind = IMM_ZERO; end
            OP_XORI:  begin alu_op = alu_XOR; ctrl = ctrl_Itype; uses_rs = 1'b1; imm_kind = IMM_ZERO; end
            OP_LUI:   begin alu_op = alu_LUI; ctrl = ctrl_Itype; imm_kind = IMM_UPPER; end
            OP_LW:    begin alu_op = alu_ADD; ctrl = ctrl_Load;  uses_rs = 1'b1; end
            OP_SW:    begin alu_op = alu_ADD; ctrl = ctrl_Store; uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BEQ:   begin alu_op = alu_BEQ; ctrl = ctrl_Branch; uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BNE:   begin alu_op = alu_BNE; ctrl = ctrl_Branch; uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_J:     ctrl = ctrl_Jump;
            OP_JAL:   begin ctrl = ctrl_JumpLink; link = 1'b1; end
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS32 decode stage with ID/EX register and handshake
// Purpose: decodes one instruction per cycle, muxes operands, computes the
// branch/jump target, detects load-use hazards and holds the result in the
// ID/EX register.
// Ports: in_valid/in_ready/pc_i/inst from IF/ID; rs_addr/rt_addr/rs_data/
// rt_data to the register file; ex_mem_read/ex_wr_addr from EX; flush;
// out_valid/out_ready and the registered decode outputs to EX.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 5,
    parameter int CTRL_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     pc_i,
    input  logic [31:0]           inst,
    output logic [REG_ADDR_W-1:0] rs_addr,
    output logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0]     src_data1,
    output logic [DATA_W-1:0]     src_data2,
    output logic [REG_ADDR_W-1:0] write_reg_addr,
    output logic [CTRL_W-1:0]     control_signal,
    output logic [DATA_W-1:0]     mem_write_data,
    output logic [DATA_W-1:0]     branch_target,
    output logic [DATA_W-1:0]     pc_o,
    output logic                  illegal
);

    logic [4:0] dec_alu_op;
    logic [7:0] dec_ctrl;
    imm_kind_e  dec_imm_kind;
    logic       dec_uses_rs, dec_uses_rt, dec_shamt, dec_link, dec_illegal;

    decode_ctrl u_decode_ctrl (
        .opcode    (inst[31:26]),
        .funct     (inst[5:0]),
        .alu_op    (dec_alu_op),
        .ctrl      (dec_ctrl),
        .imm_kind  (dec_imm_kind),
        .uses_rs   (dec_uses_rs),
        .uses_rt   (dec_uses_rt),
        .shamt_src (dec_shamt),
        .link      (dec_link),
        .illegal   (dec_illegal)
    );

    logic [REG_ADDR_W-1:0] rs_field, rt_field, rd_field, dest;
    assign rs_field = REG_ADDR_W'(inst[25:21]);
    assign rt_field = REG_ADDR_W'(inst[20:16]);
    assign rd_field = REG_ADDR_W'(inst[15:11]);
    assign rs_addr  = rst ? '0 : rs_field;
    assign rt_addr  = rst ? '0 : rt_field;

    logic [DATA_W-1:0] sext_imm, imm_ext, pc_plus4, target, src1, src2;
    assign sext_imm = DATA_W'($signed(inst[15:0]));
    assign pc_plus4 = pc_i + DATA_W'(4);

    always_comb begin
        case (dec_imm_kind)
            IMM_ZERO:  imm_ext = DATA_W'(inst[15:0]);
            IMM_UPPER: imm_ext = DATA_W'({inst[15:0], 16'h0000});
            default:   imm_ext = sext_imm;
        endcase
    end

    always_comb begin
        case (dec_ctrl[CTRL_NPC_LO +: 2])
            NPC_BRANCH: target = pc_plus4 + (sext_imm << 2);
            NPC_JIMM:   target = {pc_plus4[DATA_W-1:28], inst[25:0], 2'b00};
            NPC_JREG:   target = rs_data;
            default:    target = '0;
        endcase
    end

    assign src1 = dec_shamt ? DATA_W'(inst[10:6]) : rs_data;
    assign src2 = dec_ctrl[CTRL_SRC2] ? rt_data : imm_ext;
    assign dest = dec_link ? REG_ADDR_W'(31)
                : (dec_ctrl[CTRL_WR_SEL] ? rd_field : rt_field);

    // ID/EX register
    logic                  out_valid_q, out_valid_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0]     src_data1_q, src_data1_d, src_data2_q, src_data2_d;
    logic [REG_ADDR_W-1:0] write_reg_addr_q, write_reg_addr_d;
    logic [CTRL_W-1:0]     control_signal_q, control_signal_d;
    logic [DATA_W-1:0]     mem_write_data_q, mem_write_data_d;
    logic [DATA_W-1:0]     branch_target_q, branch_target_d, pc_o_q, pc_o_d;
    logic                  illegal_q, illegal_d;

    // A load still sitting in our own output register has not reached EX,
    // so it is checked alongside the load that EX reports.
    logic held_load, rs_hz, rt_hz, hz, load;
    assign held_load = out_valid_q && control_signal_q[CTRL_MEM_RD];
    assign rs_hz = dec_uses_rs && (rs_field != '0)
                && ((ex_mem_read && (rs_field == ex_wr_addr))
                 || (held_load && (rs_field == write_reg_addr_q)));
    assign rt_hz = dec_uses_rt && (rt_field != '0)
                && ((ex_mem_read && (rt_field == ex_wr_addr))
                 || (held_load && (rt_field == write_reg_addr_q)));
    assign hz = rs_hz || rt_hz;

    // flush does not gate in_ready: the dropped instruction is still consumed
    assign in_ready = !hz && (!out_valid_q || out_ready);
    assign load     = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d      = out_valid_q;
        alu_op_d         = alu_op_q;
        src_data1_d      = src_data1_q;
        src_data2_d      = src_data2_q;
        write_reg_addr_d = write_reg_addr_q;
        control_signal_d = control_signal_q;
        mem_write_data_d = mem_write_data_q;
        branch_target_d  = branch_target_q;
        pc_o_d           = pc_o_q;
        illegal_d        = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d      = 1'b1;
            alu_op_d         = ALU_OP_W'(dec_alu_op);
            src_data1_d      = src1;
            src_data2_d      = src2;
            write_reg_addr_d = dest;
            control_signal_d = CTRL_W'(dec_ctrl);
            mem_write_data_d = rt_data;
            branch_target_d  = target;
            pc_o_d           = pc_i;
            illegal_d        = dec_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            alu_op_q         <= '0;
            src_data1_q      <= '0;
            src_data2_q      <= '0;
            write_reg_addr_q <= '0;
            control_signal_q <= '0;
            mem_write_data_q <= '0;
            branch_target_q  <= '0;
            pc_o_q           <= '0;
            illegal_q        <= 1'b0;
        end else begin
            out_valid_q      <= out_valid_d;
            alu_op_q         <= alu_op_d;
            src_data1_q      <= src_data1_d;
            src_data2_q      <= src_data2_d;
            write_reg_addr_q <= write_reg_addr_d;
            control_signal_q <= control_signal_d;
            mem_write_data_q <= mem_write_data_d;
            branch_target_q  <= branch_target_d;
            pc_o_q           <= pc_o_d;
            illegal_q        <= illegal_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign alu_op         = alu_op_q;
    assign src_data1      = src_data1_q;
    assign src_data2      = src_data2_q;
    assign write_reg_addr = write_reg_addr_q;
    assign control_signal = control_signal_q;
    assign mem_write_data = mem_write_data_q;
    assign branch_target  = branch_target_q;
    assign pc_o           = pc_o_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0;
    logic        out_ready = 1'b0, ex_mem_read = 1'b0;
    logic [31:0] pc_i = '0, inst = '0, rs_data = '0, rt_data = '0;
    logic [4:0]  ex_wr_addr = '0;
    logic        in_ready, out_valid, illegal;
    logic [4:0]  rs_addr, rt_addr, write_reg_addr, alu_op;
    logic [31:0] src_data1, src_data2, mem_write_data, branch_target, pc_o;
    logic [7:0]  control_signal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst(inst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .ex_mem_read(ex_mem_read),
        .ex_wr_addr(ex_wr_addr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .src_data1(src_data1),
        .src_data2(src_data2), .write_reg_addr(write_reg_addr),
        .control_signal(control_signal), .mem_write_data(mem_write_data),
        .branch_target(branch_target), .pc_o(pc_o), .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  alu;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  wr;
        logic [7:0]  ctrl;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  ex_wr;
        logic        rdy;
    } hz_t;

    vec_t v[16];
    hz_t  h[5];

    initial begin
        v[0]  = '{32'h2022FFFF, 32'h40, 32'd5, 32'd9, alu_ADD, 32'd5, 32'hFFFFFFFF, 5'd2, 8'h0C, 32'h0, 1'b0};      // ADDI $2,$1,-1
        v[1]  = '{32'h34038000, 32'h44, 32'd0, 32'd9, alu_OR, 32'd0, 32'h00008000, 5'd3, 8'h0C, 32'h0, 1'b0};       // ORI $3,$0,0x8000
        v[2]  = '{32'h3C041234, 32'h48, 32'h77, 32'd9, alu_LUI, 32'h77, 32'h12340000, 5'd4, 8'h0C, 32'h0, 1'b0};    // LUI $4,0x1234
        v[3]  = '{32'h3822FFFF, 32'h4C, 32'd1, 32'd2, alu_XOR, 32'd1, 32'h0000FFFF, 5'd2, 8'h0C, 32'h0, 1'b0};      // XORI zero-ext
        v[4]  = '{32'h00A73020, 32'h50, 32'h11, 32'h22, alu_ADD, 32'h11, 32'h22, 5'd6, 8'h0F, 32'h0, 1'b0};         // ADD $6,$5,$7
        v[5]  = '{32'h00094100, 32'h54, 32'hAAAA, 32'h33, alu_SLL, 32'd4, 32'h33, 5'd8, 8'h0F, 32'h0, 1'b0};        // SLL $8,$9,4
        v[6]  = '{32'h8C250000, 32'h58, 32'h1000, 32'd5, alu_ADD, 32'h1000, 32'h0, 5'd5, 8'h18, 32'h0, 1'b0};       // LW $5,0($1)
        v[7]  = '{32'hAC250008, 32'h5C, 32'h1000, 32'h5A5A, alu_ADD, 32'h1000, 32'h8, 5'd5, 8'h20, 32'h0, 1'b0};    // SW $5,8($1)
        v[8]  = '{32'h1022FFFF, 32'h100, 32'd1, 32'd2, alu_BEQ, 32'd1, 32'd2, 5'd2, 8'hC2, 32'h100, 1'b0};          // BEQ -1
        v[9]  = '{32'h08000040, 32'h100, 32'd3, 32'd4, alu_NOP, 32'd3, 32'h40, 5'd0, 8'h80, 32'h100, 1'b0};         // J 0x40
        v[10] = '{32'h0C000040, 32'hF0000000, 32'd3, 32'd4, alu_NOP, 32'd3, 32'h40, 5'd31, 8'h8C, 32'hF0000100, 1'b0}; // JAL
        v[11] = '{32'h03E00008, 32'h200, 32'h1234, 32'd4, alu_NOP, 32'h1234, 32'h8, 5'd0, 8'h40, 32'h1234, 1'b0};   // JR $31
        v[12] = '{32'hFC000000, 32'h300, 32'd6, 32'd7, alu_NOP, 32'd6, 32'h0, 5'd0, 8'h00, 32'h0, 1'b1};            // opcode 0x3F
        v[13] = '{32'h0000003F, 32'h304, 32'd6, 32'd7, alu_NOP, 32'd6, 32'h3F, 5'd0, 8'h00, 32'h0, 1'b1};           // funct 0x3F
        v[14] = '{32'h14220002, 32'h200, 32'd1, 32'd2, alu_BNE, 32'd1, 32'd2, 5'd2, 8'hC2, 32'h20C, 1'b0};          // BNE +2
        v[15] = '{32'h2C228000, 32'h60, 32'd1, 32'd2, alu_SLTU, 32'd1, 32'hFFFF8000, 5'd2, 8'h0C, 32'h0, 1'b0};     // SLTIU sext

        h[0] = '{32'h00A73020, 5'd5, 1'b0};  // ADD reads rs=5
        h[1] = '{32'h00A73020, 5'd7, 1'b0};  // ADD reads rt=7
        h[2] = '{32'h03E00008, 5'd31, 1'b0}; // JR reads rs=31
        h[3] = '{32'h8C270000, 5'd7, 1'b1};  // LW $7: rt is destination, not read
        h[4] = '{32'h34038000, 5'd0, 1'b1};  // ORI rs=$0 never stalls

        // Reset state
        inst = 32'h00A73020;
        #1;
        chk("rs_addr_in_rst", 32'(rs_addr), 32'd0);
        chk("rt_addr_in_rst", 32'(rt_addr), 32'd0);
        tick;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_control", 32'(control_signal), 32'd0);
        chk("rst_src2", src_data2, 32'd0);
        chk("rst_pc_o", pc_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        chk("rs_addr_after_rst", 32'(rs_addr), 32'd5);
        chk("rt_addr_after_rst", 32'(rt_addr), 32'd7);

        // Table-driven decode vectors
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            inst = v[i].inst; pc_i = v[i].pc; rs_data = v[i].rs; rt_data = v[i].rt;
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick;
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(v[i].alu));
            chk($sformatf("v%0d_src1", i), src_data1, v[i].s1);
            chk($sformatf("v%0d_src2", i), src_data2, v[i].s2);
            chk($sformatf("v%0d_wr_addr", i), 32'(write_reg_addr), 32'(v[i].wr));
            chk($sformatf("v%0d_ctrl", i), 32'(control_signal), 32'(v[i].ctrl));
            chk($sformatf("v%0d_target", i), branch_target, v[i].tgt);
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(v[i].ill));
            chk($sformatf("v%0d_mem_wdata", i), mem_write_data, v[i].rt);
            chk($sformatf("v%0d_pc_o", i), pc_o, v[i].pc);
            tick;
            chk($sformatf("v%0d_drain", i), 32'(out_valid), 32'd0);
        end

        // Hazards reported by EX
        ex_mem_read = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inst = h[i].inst; ex_wr_addr = h[i].ex_wr;
            #1;
            chk($sformatf("hz%0d_in_ready", i), 32'(in_ready), 32'(h[i].rdy));
        end
        ex_mem_read = 1'b0;
        inst = 32'h00A73020;
        #1;
        chk("hz_cleared_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;

        // Load-use: LW $5 then ADD $6,$5,$7
        inst = 32'h8C250000; rs_data = 32'h1000; rt_data = 32'd0; in_valid = 1'b1;
        tick;
        inst = 32'h00A73020; rs_data = 32'h11; rt_data = 32'h22;
        #1;
        chk("lu_in_ready_stall", 32'(in_ready), 32'd0);
        chk("lu_rs_addr", 32'(rs_addr), 32'd5);
        chk("lu_lw_valid", 32'(out_valid), 32'd1);
        tick;
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_in_ready_free", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("lu_add_valid", 32'(out_valid), 32'd1);
        chk("lu_add_wr", 32'(write_reg_addr), 32'd6);
        chk("lu_add_alu", 32'(alu_op), 32'(alu_ADD));
        tick;

        // Backpressure: ORI held for 3 cycles, XORI waiting
        inst = 32'h34038000; rs_data = 32'd0; in_valid = 1'b1;
        tick;
        out_ready = 1'b0;
        inst = 32'h3822FFFF; rs_data = 32'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_src2", c), src_data2, 32'h00008000);
            chk($sformatf("bp%0d_wr", c), 32'(write_reg_addr), 32'd3);
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("bp_next_src2", src_data2, 32'h0000FFFF);
        chk("bp_next_wr", 32'(write_reg_addr), 32'd2);
        tick;

        // Flush together with in_valid while idle
        inst = 32'h00A73020; in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_no_entry", 32'(out_valid), 32'd0);

        // Flush kills a held output under backpressure
        inst = 32'h34038000; rs_data = 32'd0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_held", 32'(out_valid), 32'd0);

        // Reset in the middle of a load-use stall
        out_ready = 1'b1;
        inst = 32'h8C250000; rs_data = 32'h1000; in_valid = 1'b1;
        tick;
        out_ready = 1'b0;
        inst = 32'h00A73020;
        #1;
        chk("rst_stall_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick;
        chk("rst_stall_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_ctrl", 32'(control_signal), 32'd0);
        chk("rst_stall_wr", 32'(write_reg_addr), 32'd0);
        chk("rst_stall_rs_addr", 32'(rs_addr), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_stall_in_ready_after", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
